// File: rtl/ysyx_23060061_inst_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {inst, pc} with valid/ready on both sides and flush.
// Define YSYX_23060061_IQ_BYPASS_EN to pass an entry straight through an empty queue in the same cycle.
module ysyx_23060061_inst_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_inst,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_inst,
  output logic [XLEN-1:0]          out_pc,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];

  logic [AW:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0] wr_idx, rd_idx;
  logic          empty, full;
  logic          bypass;
  logic          enq, deq;

  assign wr_idx = wr_ptr_reg[AW-1:0];
  assign rd_idx = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

  // in_ready depends only on registered state plus rst/flush, never on out_ready.
  assign in_ready = !full && !rst && !flush;

`ifdef YSYX_23060061_IQ_BYPASS_EN
  assign bypass    = empty && in_valid && out_ready && !flush && !rst;
  assign out_valid = (!empty || (in_valid && empty)) && !flush && !rst;
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty && !flush && !rst;
`endif

  // A bypassed entry is consumed directly, so it neither writes storage nor moves a pointer.
  assign enq = in_valid && in_ready && !bypass;
  assign deq = out_valid && out_ready && !empty;

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      if (bypass || empty) begin
        out_inst = in_inst;
        out_pc   = in_pc;
      end else begin
        out_inst = inst_mem[rd_idx];
        out_pc   = pc_mem[rd_idx];
      end
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (enq) wr_ptr_next = wr_ptr_reg + PTR_ONE;
      if (deq) rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_idx] <= in_inst;
      pc_mem[wr_idx]   <= in_pc;
    end
  end

  assign count = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: tb/tb_ysyx_23060061_inst_queue.sv
// Directed bench for ysyx_23060061_inst_queue (DEPTH=4, XLEN=32); inputs change on the falling edge.
module tb_ysyx_23060061_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        flush;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  ysyx_23060061_inst_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_ready(out_ready),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    tick();
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL reset_hold: out_valid=%b in_ready=%b count=%0d required 0 0 0", out_valid, in_ready, count);
    end
    rst = 1'b0;
    tick();
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0 || out_pc !== 32'd0 || out_inst !== 32'd0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b count=%0d pc=%h inst=%h required 1 0 0 0 0",
               in_ready, out_valid, count, out_pc, out_inst);
    end
    $display("reset done");
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0000 + 32'(k * 4); in_inst = 32'h13 + 32'(k);
      #1;
      total++;
      if (in_ready !== 1'b1) begin
        bad++;
        $display("FAIL fill_ready k=%0d: in_ready=%b required 1", k, in_ready);
      end
      tick();
      $display("enqueue pc=%h", in_pc);
    end
    in_pc = 32'h8000_0010; in_inst = 32'h17;
    #1;
    total++;
    if (count !== 3'd4 || in_ready !== 1'b0 || out_pc !== 32'h8000_0000) begin
      bad++;
      $display("FAIL full_state: count=%0d in_ready=%b head=%h required 4 0 80000000", count, in_ready, out_pc);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd4) begin
      bad++;
      $display("FAIL fifth_rejected: count=%0d required 4", count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 + 32'(k * 4) || out_inst !== 32'h13 + 32'(k)) begin
        bad++;
        $display("FAIL drain k=%0d: valid=%b pc=%h inst=%h required 1 %h %h", k, out_valid, out_pc, out_inst,
                 32'h8000_0000 + 32'(k * 4), 32'h13 + 32'(k));
      end
      $display("dequeue pc=%h", out_pc);
      tick();
    end
    out_ready = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'd0) begin
      bad++;
      $display("FAIL drained: count=%0d valid=%b pc=%h required 0 0 0", count, out_valid, out_pc);
    end
  endtask

  task automatic test_full_traffic();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h1008; exp_pc[1] = 32'h100C; exp_pc[2] = 32'h2004;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 32'h1000 + 32'(k * 4); in_inst = 32'h500 + 32'(k);
      tick();
    end
    in_valid = 1'b1; in_pc = 32'h2000; in_inst = 32'h600; out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h1000) begin
      bad++;
      $display("FAIL full_both: in_ready=%b valid=%b head=%h required 0 1 1000", in_ready, out_valid, out_pc);
    end
    tick();
    in_pc = 32'h2004; in_inst = 32'h601;
    #1;
    total++;
    if (count !== 3'd3 || out_pc !== 32'h1004 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL after_full_both: count=%0d head=%h in_ready=%b required 3 1004 1", count, out_pc, in_ready);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd3 || out_pc !== 32'h1008) begin
      bad++;
      $display("FAIL steady_both: count=%0d head=%h required 3 1008", count, out_pc);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin
        bad++;
        $display("FAIL traffic_drain k=%0d: valid=%b pc=%h required 1 %h", k, out_valid, out_pc, exp_pc[k]);
      end
      $display("dequeue pc=%h", out_pc);
      tick();
    end
    out_ready = 1'b0;
    #1;
    total++;
    if (count !== 3'd0) begin
      bad++;
      $display("FAIL traffic_empty: count=%0d required 0", count);
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while (got < 10 && cyc < 60) begin
      in_valid  = (sent < 10);
      in_pc     = 32'h3000 + 32'(sent * 4);
      in_inst   = 32'h100 + 32'(sent);
      out_ready = (cyc % 3 != 2);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (out_pc !== 32'h3000 + 32'(got * 4) || out_inst !== 32'h100 + 32'(got)) begin
          bad++;
          $display("FAIL wrap_seq n=%0d: pc=%h inst=%h required %h %h", got, out_pc, out_inst,
                   32'h3000 + 32'(got * 4), 32'h100 + 32'(got));
        end
        $display("wrap dequeue pc=%h", out_pc);
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total++;
    if (got != 10 || count !== 3'd0) begin
      bad++;
      $display("FAIL wrap_total: received=%0d count=%0d required 10 0", got, count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_pc = 32'h4000 + 32'(k * 4); in_inst = 32'h700 + 32'(k);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h4FF0; in_inst = 32'h7FF;
    #1;
    total++;
    if (count !== 3'd3 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_pc !== 32'd0) begin
      bad++;
      $display("FAIL flush_cycle: count=%0d valid=%b in_ready=%b pc=%h required 3 0 0 0",
               count, out_valid, in_ready, out_pc);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL after_flush: count=%0d valid=%b required 0 0", count, out_valid);
    end
    in_valid = 1'b1; in_pc = 32'h5000; in_inst = 32'h800;
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd1 || out_pc !== 32'h5000 || out_inst !== 32'h800) begin
      bad++;
      $display("FAIL post_flush_head: count=%0d pc=%h inst=%h required 1 5000 800", count, out_pc, out_inst);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("flush done");
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_pc = 32'h6000; in_inst = 32'h900; out_ready = 1'b1;
    #1;
`ifdef YSYX_23060061_IQ_BYPASS_EN
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h6000 || out_inst !== 32'h900 || count !== 3'd0) begin
      bad++;
      $display("FAIL bypass_same_cycle: valid=%b pc=%h inst=%h count=%0d required 1 6000 900 0",
               out_valid, out_pc, out_inst, count);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL bypass_after: valid=%b count=%0d required 0 0", out_valid, count);
    end
`else
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'd0) begin
      bad++;
      $display("FAIL latency_n: valid=%b pc=%h required 0 0", out_valid, out_pc);
    end
    tick();
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h6000 || count !== 3'd1) begin
      bad++;
      $display("FAIL latency_n1: valid=%b pc=%h count=%0d required 1 6000 1", out_valid, out_pc, count);
    end
    tick();
`endif
    out_ready = 1'b0;
    $display("latency done");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_pc = 32'h7000 + 32'(k * 4); in_inst = 32'hA00 + 32'(k);
      tick();
    end
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_pc !== 32'd0) begin
      bad++;
      $display("FAIL reset_mid: count=%0d valid=%b in_ready=%b pc=%h required 0 0 1 0",
               count, out_valid, in_ready, out_pc);
    end
    $display("reset mid-operation done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_traffic();
    test_wrap();
    test_flush();
    test_latency();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
